// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   PORT_CPU    : index of the CPU load/store port (port 0)
//   PORT_LDR    : index of the program loader/debug port (port 1)
//   CNT_W       : wait-counter width, wide enough for LATENCY-1 with LATENCY <= 4
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int CNT_W = 2;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selector for the two-port memory arbiter.
//   req0, req1 : pending requests of port 0 (CPU) and port 1 (loader)
//   last       : index of the port granted most recently
//   winner     : index of the port to grant now
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; without it
// port 0 always wins a tie. A lone requester always wins in either build.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the history bit.
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = ~last;
`else
      winner = PORT_CPU;
`endif
    end else if (req1) begin
      winner = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises word accesses from the CPU port (0) and the
// loader/debug port (1) onto a single-port data memory, one transaction at a
// time.
//   clk, rst                    : rising-edge clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*       : requester inputs, held until the matching ack
//   ack*/rdata*                 : one-cycle completion pulse and held read data
//   stall                       : req0 & ~ack0, combinational CPU stall
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         : registered memory controls and read data
// Build option: MEM_ARB_ROUND_ROBIN_EN (tie-breaking inside arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_reg;
  logic              win_reg;
  logic              mem_en_reg, mem_we_reg;
  logic [ADDR_W-3:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              ack0_reg, ack1_reg;
  logic [DATA_W-1:0] rdata0_reg, rdata1_reg;

  logic pick;
  logic grant;
  logic capture;

  // Byte-lane bits are not used: every access is a whole word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[1:0], addr1[1:0]};

  arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_reg),
    .winner (pick)
  );

  assign grant = (state_reg == IDLE) && (req0 || req1);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) state_next = ISSUE;
      end
      ISSUE: begin
        // With single-cycle latency the issue cycle is also the capture cycle.
        if (LATENCY == 1) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Counter was loaded with LATENCY-1; the cycle that takes it to zero
        // is the one where the memory data is valid.
        if (cnt_reg == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      last_reg      <= PORT_LDR;
      win_reg       <= PORT_CPU;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
      rdata0_reg    <= '0;
      rdata1_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mem_en_reg <= grant;
      // The memory control registers double as the request latch, so the
      // requester's later input changes never reach the memory.
      if (grant) begin
        win_reg       <= pick;
        last_reg      <= pick;
        mem_we_reg    <= pick ? we1 : we0;
        mem_addr_reg  <= pick ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
        mem_wdata_reg <= pick ? wdata1 : wdata0;
      end else begin
        mem_we_reg <= 1'b0;
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= CNT_LOAD;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      ack0_reg <= capture && (win_reg == PORT_CPU);
      ack1_reg <= capture && (win_reg == PORT_LDR);
      if (capture) begin
        if (win_reg == PORT_CPU) rdata0_reg <= mem_rdata;
        else                     rdata1_reg <= mem_rdata;
      end
    end
  end

  assign ack0      = ack0_reg;
  assign ack1      = ack1_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;
  assign stall     = req0 & ~ack0_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter instances (LATENCY 1, 3, 4) driven by
// randomized requesters and checked cycle by cycle against a transaction-level
// timeline model (grant cycle C -> mem_en C+1, capture C+L, ack C+L+1,
// idle again C+L+2).
module tb_mem_arbiter;

  localparam int NI = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [NI-1:0]         req0_v, req1_v, we0_v, we1_v;
  logic [NI-1:0][AW-1:0] addr0_v, addr1_v;
  logic [NI-1:0][DW-1:0] wdata0_v, wdata1_v, rdata0_v, rdata1_v;
  logic [NI-1:0][DW-1:0] mem_wdata_v, mem_rdata_v;
  logic [NI-1:0]         ack0_v, ack1_v, stall_v, mem_en_v, mem_we_v;
  logic [NI-1:0][AW-3:0] mem_addr_v;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(lat_of(gi))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0_v[gi]),
      .req1      (req1_v[gi]),
      .we0       (we0_v[gi]),
      .we1       (we1_v[gi]),
      .addr0     (addr0_v[gi]),
      .addr1     (addr1_v[gi]),
      .wdata0    (wdata0_v[gi]),
      .wdata1    (wdata1_v[gi]),
      .ack0      (ack0_v[gi]),
      .ack1      (ack1_v[gi]),
      .rdata0    (rdata0_v[gi]),
      .rdata1    (rdata1_v[gi]),
      .stall     (stall_v[gi]),
      .mem_en    (mem_en_v[gi]),
      .mem_we    (mem_we_v[gi]),
      .mem_addr  (mem_addr_v[gi]),
      .mem_wdata (mem_wdata_v[gi]),
      .mem_rdata (mem_rdata_v[gi])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction timeline per instance.
  int          cyc;
  int          mode;        // 0 none, 1 random, 2 both continuous, 3 drop in ISSUE
  bit          ovr;
  logic [31:0] ovr_val;
  int          c_cyc   [NI];
  int          free_at [NI];
  bit          m_last  [NI];
  bit          m_win   [NI];
  bit          m_we    [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_data  [NI];
  logic [31:0] exp_rd  [NI][2];
  bit          rd_known[NI][2];
  // Requesters
  bit          pend    [NI][2];
  bit          p_we    [NI][2];
  logic [31:0] p_addr  [NI][2];
  logic [31:0] p_wdata [NI][2];

  function automatic bit inflight(input int i);
    return cyc < free_at[i];
  endfunction

  task automatic drive(input int i);
    req0_v[i]   = pend[i][0];
    req1_v[i]   = pend[i][1];
    we0_v[i]    = p_we[i][0];
    we1_v[i]    = p_we[i][1];
    addr0_v[i]  = p_addr[i][0];
    addr1_v[i]  = p_addr[i][1];
    wdata0_v[i] = p_wdata[i][0];
    wdata1_v[i] = p_wdata[i][1];
  endtask

  task automatic inject(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < NI; i++) begin
      pend[i][p] = 1'b1; p_we[i][p] = we; p_addr[i][p] = a; p_wdata[i][p] = d;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      int L;
      L = lat_of(i);
      for (int p = 0; p < 2; p++) begin
        bit busy_p;
        bit go;
        busy_p = inflight(i) && (m_win[i] == p[0]) && (cyc < c_cyc[i] + L + 1);
        if (inflight(i) && (m_win[i] == p[0]) && (cyc == c_cyc[i] + L + 1)) pend[i][p] = 1'b0;
        if (mode == 3 && busy_p && cyc == c_cyc[i] + 1) pend[i][p] = 1'b0;
        if (!pend[i][p] && !busy_p) begin
          go = (mode == 2) || ((mode == 1 || mode == 3) && $urandom_range(0, 2) == 0);
          if (go) begin
            pend[i][p]    = 1'b1;
            p_we[i][p]    = 1'($urandom_range(0, 1));
            p_addr[i][p]  = $urandom;
            p_wdata[i][p] = $urandom;
          end
        end else if (mode == 1 && pend[i][p] && busy_p && cyc > c_cyc[i]) begin
          p_we[i][p]    = 1'($urandom_range(0, 1));
          p_addr[i][p]  = $urandom;
          p_wdata[i][p] = $urandom;
        end
      end
      drive(i);
      if (!inflight(i) && (pend[i][0] || pend[i][1])) begin
        bit w;
        if (pend[i][0] && pend[i][1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w = ~m_last[i];
`else
          w = 1'b0;
`endif
        end else begin
          w = ~pend[i][0];
        end
        m_win[i]   = w;
        m_last[i]  = w;
        m_we[i]    = p_we[i][w];
        m_addr[i]  = p_addr[i][w];
        m_wdata[i] = p_wdata[i][w];
        m_data[i]  = ovr ? ovr_val : $urandom;
        c_cyc[i]   = cyc;
        free_at[i] = cyc + L + 2;
      end
      mem_rdata_v[i] = (inflight(i) && cyc == c_cyc[i] + L) ? m_data[i] : $urandom;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      int L;
      bit issue;
      bit ackc;
      L     = lat_of(i);
      issue = inflight(i) && cyc == c_cyc[i] + 1;
      ackc  = inflight(i) && cyc == c_cyc[i] + L + 1;
      if (ackc) begin
        exp_rd[i][m_win[i]]   = m_data[i];
        rd_known[i][m_win[i]] = ~m_we[i];
        $display("txn cyc=%0d inst=%0d lat=%0d port=%0d %s addr=%h wdata=%h rdata=%h",
                 cyc, i, L, m_win[i], m_we[i] ? "WR" : "RD", m_addr[i], m_wdata[i], m_data[i]);
      end
      check($sformatf("i%0d_mem_en c%0d", i, cyc), 64'(mem_en_v[i]), 64'(issue));
      if (issue) begin
        check($sformatf("i%0d_mem_we c%0d", i, cyc), 64'(mem_we_v[i]), 64'(m_we[i]));
        check($sformatf("i%0d_mem_addr c%0d", i, cyc), 64'(mem_addr_v[i]), 64'(m_addr[i] >> 2));
        check($sformatf("i%0d_mem_wdata c%0d", i, cyc), 64'(mem_wdata_v[i]), 64'(m_wdata[i]));
      end
      check($sformatf("i%0d_ack0 c%0d", i, cyc), 64'(ack0_v[i]), 64'(ackc && m_win[i] == 1'b0));
      check($sformatf("i%0d_ack1 c%0d", i, cyc), 64'(ack1_v[i]), 64'(ackc && m_win[i] == 1'b1));
      check($sformatf("i%0d_stall c%0d", i, cyc), 64'(stall_v[i]),
            64'(pend[i][0] && !(ackc && m_win[i] == 1'b0)));
      if (rd_known[i][0]) check($sformatf("i%0d_rdata0 c%0d", i, cyc), 64'(rdata0_v[i]), 64'(exp_rd[i][0]));
      if (rd_known[i][1]) check($sformatf("i%0d_rdata1 c%0d", i, cyc), 64'(rdata1_v[i]), 64'(exp_rd[i][1]));
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < 2; p++) begin
          pend[i][p] = 1'b0; p_we[i][p] = 1'b0; p_addr[i][p] = '0; p_wdata[i][p] = '0;
          exp_rd[i][p] = '0; rd_known[i][p] = 1'b1;
        end
        free_at[i] = 0;
        m_last[i]  = 1'b1;
        drive(i);
        mem_rdata_v[i] = $urandom;
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("i%0d_rst_ack0 c%0d", i, cyc), 64'(ack0_v[i]), 64'd0);
        check($sformatf("i%0d_rst_ack1 c%0d", i, cyc), 64'(ack1_v[i]), 64'd0);
        check($sformatf("i%0d_rst_mem_en c%0d", i, cyc), 64'(mem_en_v[i]), 64'd0);
        check($sformatf("i%0d_rst_mem_we c%0d", i, cyc), 64'(mem_we_v[i]), 64'd0);
        check($sformatf("i%0d_rst_mem_addr c%0d", i, cyc), 64'(mem_addr_v[i]), 64'd0);
        check($sformatf("i%0d_rst_mem_wdata c%0d", i, cyc), 64'(mem_wdata_v[i]), 64'd0);
        check($sformatf("i%0d_rst_rdata0 c%0d", i, cyc), 64'(rdata0_v[i]), 64'd0);
        check($sformatf("i%0d_rst_rdata1 c%0d", i, cyc), 64'(rdata1_v[i]), 64'd0);
        check($sformatf("i%0d_rst_stall c%0d", i, cyc), 64'(stall_v[i]), 64'd0);
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1;
    cyc = 0; mode = 0; ovr = 1'b0; ovr_val = '0;
    for (int i = 0; i < NI; i++) begin
      free_at[i] = 0; c_cyc[i] = -1000; m_last[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        pend[i][p] = 1'b0; p_we[i][p] = 1'b0; p_addr[i][p] = '0; p_wdata[i][p] = '0;
      end
      drive(i);
      mem_rdata_v[i] = '0;
    end
    do_reset(3);

    // Directed: CPU read of 0x10 returning 0xDEADBEEF.
    ovr = 1'b1; ovr_val = 32'hDEAD_BEEF;
    inject(0, 1'b0, 32'h0000_0010, 32'h0);
    run(8);
    // Directed: loader write of 0x12345678 to 0x20.
    ovr = 1'b0;
    inject(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    run(8);
    // Directed: misaligned CPU read of 0x13.
    inject(0, 1'b0, 32'h0000_0013, 32'h0);
    run(8);

    // Both ports requesting continuously.
    mode = 2; run(30);
    mode = 0; run(8);
    // Requests dropped in the ISSUE cycle.
    mode = 3; run(60);
    mode = 0; run(8);
    // Random traffic with post-grant input scrambling.
    mode = 1; run(400);
    mode = 0; run(8);

    // Reset asserted while the LATENCY=4 instance is in WAIT.
    mode = 2;
    k = 0;
    while (!(inflight(2) && (cyc + 1 - c_cyc[2]) == 2) && k < 40) begin
      step();
      k++;
    end
    check("reach_wait_before_reset", 64'(k < 40), 64'd1);
    do_reset(2);
    mode = 2; run(30);
    mode = 0; run(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
